filter: RTL and testbench
=========================

Name: filter

Overview:
Streaming moving-average (boxcar) filter over the most recent 2^M accepted input samples. It accepts one N-bit unsigned sample per cycle when sample_valid is high. It emits the truncated mean of the last 2^M samples with a registered valid strobe. It sits inline in a sample datapath between a producer and a consumer; neither side applies backpressure.

Parameters:
M  2  log2 of window length; window = 2^M samples; legal range 0..8
N  8  bit width of input samples and output average; legal range 1..32

Ports:
clk            input   1  clock; all state updates on rising edge
rstn           input   1  asynchronous reset, active low
sample         input   N  unsigned input sample; sampled only when sample_valid=1
sample_valid   input   1  active high; qualifies sample for the current cycle
average        output  N  unsigned mean of the last 2^M accepted samples
average_valid  output  1  active high one-cycle strobe qualifying a new average

Behaviour:
- Single clock domain (clk). rstn is asynchronous active-low; its deassertion is synchronous to clk and is handled by the surrounding design.
- Reset (rstn=0), applied immediately and asynchronously:
  - average = 0, average_valid = 0.
  - History buffer = all zeros, running sum = 0, fill counter = 0, write pointer = 0.
- Storage:
  - Circular buffer of 2^M entries, each N bits, with an M-bit write pointer that wraps naturally.
  - Running sum register, N+M bits wide, so it never overflows.
- Accepted sample (sample_valid=1 at a rising edge):
  - sum_next = sum + sample - buf[wptr]. The entry being overwritten is the oldest one, or 0 while the buffer is still filling.
  - buf[wptr] = sample; wptr = wptr + 1 mod 2^M.
  - The fill counter increments, saturating at 2^M.
- Output:
  - On the same edge as an accepted sample, average = sum_next >> M. The shift is a floor division by 2^M; no rounding.
  - average_valid = 1 on that edge only if the fill counter, after the increment, equals 2^M. Otherwise average_valid = 0.
  - Latency: one clock from the accepting edge to average/average_valid.
- Warm-up:
  - The first 2^M-1 accepted samples after reset produce no valid strobe.
  - average still updates during warm-up (partial sum / 2^M) but is not qualified.
- Idle cycles (sample_valid=0):
  - No state change; average holds its last value; average_valid = 0.
  - Gaps of any length between samples are allowed; history is preserved across gaps.
- Back-to-back samples on every cycle are supported at full throughput, one average per cycle once filled.
- M = 0: window of 1; average = previous accepted sample, registered; valid on every accepted sample.
- Result range: the result always fits in N bits, since the maximum is (2^N-1)·2^M >> M = 2^N-1.
- Reset mid-operation: all history is discarded. A fresh 2^M samples are required before the next average_valid.
- X/undefined sample values while sample_valid=0 must not affect state.

Test Plan:
Values below use M=2, N=8.
- Reset: hold rstn=0 for 10 cycles with random sample/sample_valid -> average=0 and average_valid=0 throughout; assert rstn low mid-cycle -> outputs clear without waiting for a clock edge.
- Warm-up: after reset, feed 10,20,30,40 on consecutive cycles -> average_valid low after samples 1-3; one cycle after 40, average_valid=1 and average=25.
- Sliding window: continue with 50, then 60 -> average=35, then 45, each with a valid strobe. Then sample_valid=0 for 5 cycles -> average holds 45 and average_valid=0.
- Gaps and truncation: after reset, feed 1 idle, 1 idle idle, 1, 2, with gaps -> one cycle after 2, average=1 (5/4 truncated) with valid; idle cycles never produce valid.
- Extremes: feed 255 x4 -> average=255, no overflow; then 0 x4 -> averages 191, 127, 63, 0.
- Reset mid-stream: feed 3 samples, pulse rstn low, then feed 4,4,4,8 -> no valid until the 4th post-reset sample; average=5. A random burst of 4/10/2/3 samples with idle cycles between bursts -> every valid average equals floor(sum of last 4 accepted samples / 4) against a reference model.

Source files
------------

// File: rtl/filter.sv
// Streaming boxcar filter: emits the floor mean of the most recent 2^M accepted
// samples, qualified by a one-cycle strobe once the window has filled.
module filter #(
  parameter int M = 2,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] sample,
  input  logic         sample_valid,
  output logic [N-1:0] average,
  output logic         average_valid
);

  localparam int DEPTH = 1 << M;
  localparam int SUM_W = N + M;
  localparam int PTR_W = (M > 0) ? M : 1;
  localparam int CNT_W = M + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Floor division by the window length; the quotient always fits in N bits.
  function automatic logic [N-1:0] floor_avg(input logic [SUM_W-1:0] s);
    return N'(s >> M);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == FULL) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [N-1:0]     hist [DEPTH];
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] fill;
  logic [PTR_W-1:0] wptr;

  logic [N-1:0]     oldest_p0;
  logic [SUM_W-1:0] sum_p0;
  logic [CNT_W-1:0] fill_p0;

  // Stage p0: next running sum; the retiring entry is still zero while filling,
  // and the sum always contains it, so the subtraction cannot underflow.
  always_comb begin
    oldest_p0 = hist[wptr];
    sum_p0    = sum + SUM_W'(sample) - SUM_W'(oldest_p0);
    fill_p0   = sat_inc(fill);
  end

  // Stage p1: commit history and register the qualified average.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      sum           <= '0;
      fill          <= '0;
      wptr          <= '0;
      average       <= '0;
      average_valid <= 1'b0;
    end else begin
      average_valid <= 1'b0;
      if (sample_valid) begin
        hist[wptr]    <= sample;
        wptr          <= wrap_inc(wptr);
        sum           <= sum_p0;
        fill          <= fill_p0;
        average       <= floor_avg(sum_p0);
        average_valid <= (fill_p0 == FULL);
      end
    end
  end

endmodule

// File: tb/tb_filter.sv
// Directed bench for the boxcar filter at M=2, N=8.
module tb_filter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] sample = 8'd0;
  logic       sample_valid = 1'b0;
  logic [7:0] average;
  logic       average_valid;

  int total = 0;
  int bad = 0;

  int         hist_q[$];
  logic [7:0] last_avg;

  filter #(.M(2), .N(8)) dut (
    .clk(clk),
    .rstn(rstn),
    .sample(sample),
    .sample_valid(sample_valid),
    .average(average),
    .average_valid(average_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp_a, input logic exp_v);
    total++;
    assert (average === exp_a && average_valid === exp_v) else begin
      bad++;
      $error("FAIL %s: got avg=%0d vld=%0b, want avg=%0d vld=%0b",
             tag, average, average_valid, exp_a, exp_v);
    end
  endtask

  // Apply inputs on the falling edge, then observe 1ns after the rising edge.
  task automatic step(input logic v, input logic [7:0] s);
    @(negedge clk);
    sample_valid = v;
    sample = s;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] s, input logic [7:0] exp_a, input logic exp_v,
                      input string tag);
    step(1'b1, s);
    check(tag, exp_a, exp_v);
  endtask

  task automatic idle(input int n, input logic [7:0] exp_a, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'($urandom));
      check(tag, exp_a, 1'b0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    sample_valid = 1'b0;
    rstn = 1'b1;
  endtask

  // Reference: floor of the sum of the last four accepted samples over four.
  task automatic model_push(input logic [7:0] s, input string tag);
    int acc;
    int n;
    hist_q.push_back(int'(s));
    n = hist_q.size();
    acc = 0;
    for (int k = (n > 4 ? n - 4 : 0); k < n; k++) acc += hist_q[k];
    last_avg = 8'(acc / 4);
    step(1'b1, s);
    check(tag, last_avg, n >= 4);
  endtask

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample = 8'($urandom);
      sample_valid = 1'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold", 8'd0, 1'b0);
    end
    release_reset();

    // Warm-up then sliding window.
    push(8'd10, 8'd2,  1'b0, "warm1");
    push(8'd20, 8'd7,  1'b0, "warm2");
    push(8'd30, 8'd15, 1'b0, "warm3");
    push(8'd40, 8'd25, 1'b1, "warm4");
    push(8'd50, 8'd35, 1'b1, "slide50");
    push(8'd60, 8'd45, 1'b1, "slide60");
    idle(5, 8'd45, "idle_hold");

    // Asynchronous assertion mid-cycle clears outputs before any edge.
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("async_reset", 8'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_low", 8'd0, 1'b0);
    release_reset();

    // Gaps and truncation: 1,1,1,2 -> 5/4 = 1.
    push(8'd1, 8'd0, 1'b0, "gap1");
    idle(1, 8'd0, "gap_idle1");
    push(8'd1, 8'd0, 1'b0, "gap2");
    idle(2, 8'd0, "gap_idle2");
    push(8'd1, 8'd0, 1'b0, "gap3");
    push(8'd2, 8'd1, 1'b1, "gap4");
    idle(1, 8'd1, "gap_idle3");

    // Extremes, window continuing from [1,1,1,2].
    push(8'd255, 8'd64,  1'b1, "max1");
    push(8'd255, 8'd128, 1'b1, "max2");
    push(8'd255, 8'd191, 1'b1, "max3");
    push(8'd255, 8'd255, 1'b1, "max4");
    push(8'd0,   8'd191, 1'b1, "zero1");
    push(8'd0,   8'd127, 1'b1, "zero2");
    push(8'd0,   8'd63,  1'b1, "zero3");
    push(8'd0,   8'd0,   1'b1, "zero4");

    // Reset mid-stream discards history.
    push(8'd7, 8'd1, 1'b1, "pre_rst1");
    push(8'd8, 8'd3, 1'b1, "pre_rst2");
    push(8'd9, 8'd6, 1'b1, "pre_rst3");
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_reset", 8'd0, 1'b0);
    release_reset();
    push(8'd4, 8'd1, 1'b0, "post1");
    push(8'd4, 8'd2, 1'b0, "post2");
    push(8'd4, 8'd3, 1'b0, "post3");
    push(8'd8, 8'd5, 1'b1, "post4");

    // Random bursts against the reference model.
    hist_q = '{4, 4, 4, 8};
    last_avg = 8'd5;
    foreach (hist_q[k]) ;
    for (int b = 0; b < 4; b++) begin
      int len;
      len = (b == 0) ? 4 : (b == 1) ? 10 : (b == 2) ? 2 : 3;
      for (int j = 0; j < len; j++) model_push(8'($urandom_range(0, 255)), "burst");
      idle(int'($urandom_range(1, 3)), last_avg, "burst_idle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
